// File: rtl/chip8_gpu_if.sv
// Bundle between the CHIP-8 sprite engine, the CPU core that issues draws
// and the memory block that serves reads and accepts byte writes.
// master: CPU + memory side (issues draws, answers reads)
// slave:  sprite engine side
interface chip8_gpu_if;
  logic        draw;
  logic [11:0] addr;
  logic [3:0]  lines;
  logic [7:0]  x;
  logic [7:0]  y;
  logic        busy;
  logic        collision;
  logic        mem_read;
  logic [11:0] mem_read_idx;
  logic [7:0]  mem_read_byte;
  logic        mem_read_ack;
  logic        mem_write;
  logic [11:0] mem_write_idx;
  logic [7:0]  mem_write_byte;

  modport master (
    output draw, addr, lines, x, y, mem_read_byte, mem_read_ack,
    input  busy, collision, mem_read, mem_read_idx,
           mem_write, mem_write_idx, mem_write_byte
  );

  modport slave (
    input  draw, addr, lines, x, y, mem_read_byte, mem_read_ack,
    output busy, collision, mem_read, mem_read_idx,
           mem_write, mem_write_idx, mem_write_byte
  );
endinterface

// File: rtl/chip8_gpu.sv
// CHIP-8 DXYN sprite-draw engine. Reads N sprite bytes, XORs each into the
// 64x32 monochrome framebuffer (8 bytes per row) living in the same memory,
// and reports whether any lit pixel was turned off.
module chip8_gpu #(
  parameter logic [11:0] FB_BASE = 12'h100
) (
  input  logic        clk,
  input  logic        reset,
  chip8_gpu_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE,
    LINE_CHK,
    READ_SPR,
    READ_L,
    WRITE_L,
    READ_R,
    WRITE_R
  } state_t;

  state_t      state_reg, state_next;
  logic [11:0] addr_reg;
  logic [3:0]  lines_reg;
  logic [5:0]  x0_reg;
  logic [4:0]  y0_reg;
  logic [4:0]  line_reg;
  logic [7:0]  spr_reg;
  logic [7:0]  old_reg;
  logic        collision_reg;

  logic [5:0]  row;
  logic [2:0]  col_l;
  logic [2:0]  col_r;
  logic [2:0]  offset;
  logic [15:0] spr_split;
  logic [7:0]  sprite_l;
  logic [7:0]  sprite_r;
  logic [11:0] fb_idx_l;
  logic [11:0] fb_idx_r;
  logic        last_line;
  logic        need_right;

  // Upper coordinate bits only matter modulo the screen size.
  logic        unused_coord_bits;
  assign unused_coord_bits = ^{bus.x[7:6], bus.y[7:5]};

  // Current line geometry. The sprite byte is split across two framebuffer
  // bytes when the start column is not byte aligned: shifting {spr,0} right
  // by the offset yields the left part in the top half, right part below.
  assign row        = 6'(y0_reg) + 6'(line_reg);
  assign col_l      = x0_reg[5:3];
  assign col_r      = col_l + 3'd1;
  assign offset     = x0_reg[2:0];
  assign spr_split  = {spr_reg, 8'h00} >> offset;
  assign sprite_l   = spr_split[15:8];
  assign sprite_r   = spr_split[7:0];
  assign fb_idx_l   = FB_BASE + {4'h0, row[4:0], col_l};
  assign fb_idx_r   = FB_BASE + {4'h0, row[4:0], col_r};
  // row[5] set means the line fell off the bottom of the screen.
  assign last_line  = (line_reg == {1'b0, lines_reg}) || row[5];
  // Rightmost byte column has no neighbour: the overflow is clipped.
  assign need_right = (offset != 3'd0) && (col_l != 3'd7);

  assign bus.collision = collision_reg;

  // Next-state and memory strobes; read and write states are disjoint so the
  // two strobes can never overlap.
  always_comb begin
    state_next         = state_reg;
    bus.busy           = (state_reg != IDLE);
    bus.mem_read       = 1'b0;
    bus.mem_read_idx   = 12'h000;
    bus.mem_write      = 1'b0;
    bus.mem_write_idx  = 12'h000;
    bus.mem_write_byte = 8'h00;
    case (state_reg)
      IDLE: begin
        if (bus.draw) state_next = LINE_CHK;
      end
      LINE_CHK: begin
        state_next = last_line ? IDLE : READ_SPR;
      end
      READ_SPR: begin
        bus.mem_read     = 1'b1;
        bus.mem_read_idx = addr_reg + 12'(line_reg);
        if (bus.mem_read_ack) state_next = READ_L;
      end
      READ_L: begin
        bus.mem_read     = 1'b1;
        bus.mem_read_idx = fb_idx_l;
        if (bus.mem_read_ack) state_next = WRITE_L;
      end
      WRITE_L: begin
        bus.mem_write      = 1'b1;
        bus.mem_write_idx  = fb_idx_l;
        bus.mem_write_byte = old_reg ^ sprite_l;
        state_next         = need_right ? READ_R : LINE_CHK;
      end
      READ_R: begin
        bus.mem_read     = 1'b1;
        bus.mem_read_idx = fb_idx_r;
        if (bus.mem_read_ack) state_next = WRITE_R;
      end
      WRITE_R: begin
        bus.mem_write      = 1'b1;
        bus.mem_write_idx  = fb_idx_r;
        bus.mem_write_byte = old_reg ^ sprite_r;
        state_next         = LINE_CHK;
      end
      default: state_next = IDLE;
    endcase
  end

  // State register plus the draw context, captured read data and collision.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      addr_reg      <= 12'h000;
      lines_reg     <= 4'h0;
      x0_reg        <= 6'h00;
      y0_reg        <= 5'h00;
      line_reg      <= 5'h00;
      spr_reg       <= 8'h00;
      old_reg       <= 8'h00;
      collision_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: begin
          if (bus.draw) begin
            addr_reg      <= bus.addr;
            lines_reg     <= bus.lines;
            x0_reg        <= bus.x[5:0];
            y0_reg        <= bus.y[4:0];
            line_reg      <= 5'h00;
            collision_reg <= 1'b0;
          end
        end
        READ_SPR: begin
          if (bus.mem_read_ack) spr_reg <= bus.mem_read_byte;
        end
        READ_L, READ_R: begin
          if (bus.mem_read_ack) old_reg <= bus.mem_read_byte;
        end
        WRITE_L: begin
          collision_reg <= collision_reg | (|(old_reg & sprite_l));
          if (!need_right) line_reg <= line_reg + 5'd1;
        end
        WRITE_R: begin
          collision_reg <= collision_reg | (|(old_reg & sprite_r));
          line_reg      <= line_reg + 5'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_chip8_gpu.sv
// Bench for chip8_gpu: memory with random read latency, a pixel-level
// model of the 64x32 screen, directed spec scenarios then random draws.
module tb_chip8_gpu;

  logic clk = 1'b0;
  logic reset;

  chip8_gpu_if bus ();

  chip8_gpu u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // memory and tb-side write port
  logic [7:0]  mem    [4096];
  logic [7:0]  shadow [4096];
  logic        tb_we, tb_clr_all, tb_clr_fb;
  logic [11:0] tb_wa;
  logic [7:0]  tb_wd;
  int          lat;

  // monitor counters
  int wr_cnt     = 0;
  int strobe_cnt = 0;
  int proto_err  = 0;

  // screen model
  bit pix [32][64];

  // memory: tb pokes, DUT writes, reads answered after 0..2 extra cycles
  always @(posedge clk) begin
    if (tb_clr_all) begin
      for (int k = 0; k < 4096; k++) mem[k] <= 8'h00;
    end else if (tb_clr_fb) begin
      for (int k = 0; k < 256; k++) mem[12'h100 + k] <= 8'h00;
    end
    if (tb_we) mem[tb_wa] <= tb_wd;
    if (bus.mem_write) mem[bus.mem_write_idx] <= bus.mem_write_byte;
    if (reset) begin
      bus.mem_read_ack <= 1'b0;
      lat <= 0;
    end else if (bus.mem_read && !bus.mem_read_ack) begin
      if (lat == 0) begin
        bus.mem_read_ack  <= 1'b1;
        bus.mem_read_byte <= mem[bus.mem_read_idx];
        lat <= $urandom_range(0, 2);
      end else begin
        lat <= lat - 1;
      end
    end else begin
      bus.mem_read_ack <= 1'b0;
    end
  end

  // bus monitor: strobe overlap, writes outside the framebuffer
  always @(posedge clk) begin
    if (!reset) begin
      if (bus.mem_write) wr_cnt <= wr_cnt + 1;
      if (bus.mem_read || bus.mem_write) strobe_cnt <= strobe_cnt + 1;
      if ((bus.mem_read && bus.mem_write) ||
          (bus.mem_write && (bus.mem_write_idx < 12'h100 || bus.mem_write_idx > 12'h1FF)))
        proto_err <= proto_err + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic poke(input logic [11:0] a, input logic [7:0] d);
    @(negedge clk);
    tb_we = 1'b1; tb_wa = a; tb_wd = d;
    shadow[a] = d;
    @(negedge clk);
    tb_we = 1'b0;
  endtask

  task automatic clear_fb();
    @(negedge clk);
    tb_clr_fb = 1'b1;
    @(negedge clk);
    tb_clr_fb = 1'b0;
    for (int r = 0; r < 32; r++)
      for (int c = 0; c < 64; c++) pix[r][c] = 1'b0;
  endtask

  // model: plain pixel XOR with wrap of the start and clip of the body
  task automatic model_draw(input logic [11:0] a, input int n, input int xx, input int yy,
                            output bit col, output int writes);
    int x0, y0, r, cc;
    logic [7:0] s;
    x0 = xx % 64; y0 = yy % 32;
    col = 1'b0; writes = 0;
    for (int i = 0; i < n; i++) begin
      r = y0 + i;
      if (r >= 32) break;
      s = shadow[a + 12'(i)];
      writes += ((x0 % 8) != 0 && (x0 / 8) < 7) ? 2 : 1;
      for (int b = 0; b < 8; b++) begin
        cc = x0 + b;
        if (cc < 64 && s[7 - b]) begin
          if (pix[r][cc]) col = 1'b1;
          pix[r][cc] = ~pix[r][cc];
        end
      end
    end
  endtask

  function automatic logic [7:0] model_byte(input int k);
    logic [7:0] v;
    for (int j = 0; j < 8; j++) v[7 - j] = pix[k / 8][(k % 8) * 8 + j];
    return v;
  endfunction

  task automatic compare_fb(input string tag);
    logic [2047:0] fb_act, fb_exp;
    int bad;
    bad = -1;
    for (int k = 0; k < 256; k++) begin
      fb_act[k*8 +: 8] = mem[12'h100 + k];
      fb_exp[k*8 +: 8] = model_byte(k);
      if (bad < 0 && fb_act[k*8 +: 8] !== fb_exp[k*8 +: 8]) bad = k;
    end
    checks++;
    assert (fb_act === fb_exp) else begin
      errors++;
      $error("FAIL %s fb byte %0h observed=%0h expected=%0h", tag, 12'h100 + bad,
             mem[12'h100 + bad], model_byte(bad));
    end
  endtask

  // one DXYN: accept, busy, completion, collision, write count, framebuffer
  task automatic do_draw(input string tag, input logic [11:0] a, input int n,
                         input int xx, input int yy, input bit spam);
    int cyc, wr0, st0, exp_wr;
    bit exp_col;
    @(negedge clk);
    bus.draw = 1'b1; bus.addr = a; bus.lines = 4'(n); bus.x = 8'(xx); bus.y = 8'(yy);
    wr0 = wr_cnt; st0 = strobe_cnt;
    @(negedge clk);
    bus.draw = 1'b0;
    check({tag, "_busy_on"}, 32'(bus.busy), 32'd1);
    cyc = 0;
    while (bus.busy === 1'b1 && cyc < 5000) begin
      if (spam && cyc == 2) begin
        bus.draw = 1'b1; bus.x = 8'(xx) ^ 8'h55; bus.y = 8'(yy) ^ 8'h0A;
      end else begin
        bus.draw = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    bus.draw = 1'b0;
    check({tag, "_done"}, 32'(cyc < 5000), 32'd1);
    model_draw(a, n, xx, yy, exp_col, exp_wr);
    check({tag, "_collision"}, 32'(bus.collision), 32'(exp_col));
    check({tag, "_writes"}, 32'(wr_cnt - wr0), 32'(exp_wr));
    if (n == 0) begin
      check({tag, "_n0_busy_cycles"}, 32'(cyc), 32'd1);
      check({tag, "_n0_strobes"}, 32'(strobe_cnt - st0), 32'd0);
    end
    compare_fb(tag);
    $display("draw %s addr=%03h n=%0d x=%0d y=%0d busy_cycles=%0d collision=%0b",
             tag, a, n, xx, yy, cyc, bus.collision);
  endtask

  logic [7:0] spr42 [5];

  initial begin
    logic [11:0] ra;
    int rn;
    reset = 1'b1;
    bus.draw = 1'b0; bus.addr = '0; bus.lines = '0; bus.x = '0; bus.y = '0;
    tb_we = 1'b0; tb_wa = '0; tb_wd = '0; tb_clr_fb = 1'b0; tb_clr_all = 1'b1;
    for (int k = 0; k < 4096; k++) shadow[k] = 8'h00;
    for (int r = 0; r < 32; r++)
      for (int c = 0; c < 64; c++) pix[r][c] = 1'b0;
    repeat (3) @(negedge clk);
    tb_clr_all = 1'b0;
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_collision", 32'(bus.collision), 32'd0);
    check("reset_mem_read", 32'(bus.mem_read), 32'd0);
    check("reset_mem_write", 32'(bus.mem_write), 32'd0);
    reset = 1'b0;

    spr42[0] = 8'hFF; spr42[1] = 8'hC3; spr42[2] = 8'hC3; spr42[3] = 8'hC3; spr42[4] = 8'hFF;
    for (int i = 0; i < 5; i++) poke(12'h042 + 12'(i), spr42[i]);

    do_draw("box_00", 12'h042, 5, 0, 0, 1'b0);
    check("box_00_0x110", 32'(mem[12'h110]), 32'hC3);
    check("box_00_0x120", 32'(mem[12'h120]), 32'hFF);
    do_draw("box_00_again", 12'h042, 5, 0, 0, 1'b0);
    check("box_00_again_0x100", 32'(mem[12'h100]), 32'h00);
    check("box_00_again_col", 32'(bus.collision), 32'd1);

    do_draw("box_y28", 12'h042, 5, 0, 28, 1'b0);
    check("box_y28_0x1F8", 32'(mem[12'h1F8]), 32'hC3);
    check("box_y28_0x200", 32'(mem[12'h200]), 32'h00);

    clear_fb();
    do_draw("box_x5", 12'h042, 5, 5, 0, 1'b1);
    check("box_x5_0x100", 32'(mem[12'h100]), 32'h07);
    check("box_x5_0x109", 32'(mem[12'h109]), 32'h18);
    do_draw("box_x5_erase", 12'h042, 5, 5, 0, 1'b0);
    do_draw("box_x61", 12'h042, 5, 61, 0, 1'b0);
    check("box_x61_0x10F", 32'(mem[12'h10F]), 32'h06);
    check("box_x61_0x108", 32'(mem[12'h108]), 32'h00);
    check("box_x61_col", 32'(bus.collision), 32'd0);

    // abort mid-draw
    clear_fb();
    for (int i = 0; i < 15; i++) poke(12'h300 + 12'(i), 8'($urandom));
    @(negedge clk);
    bus.draw = 1'b1; bus.addr = 12'h300; bus.lines = 4'd15; bus.x = 8'd3; bus.y = 8'd2;
    @(negedge clk);
    bus.draw = 1'b0;
    repeat (6) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_mem_read", 32'(bus.mem_read), 32'd0);
    check("abort_collision", 32'(bus.collision), 32'd0);
    $display("abort reset mid-draw busy=%0b", bus.busy);
    clear_fb();

    do_draw("n0", 12'h042, 0, 10, 10, 1'b0);

    // random draws against the pixel model
    for (int t = 0; t < 30; t++) begin
      if ($urandom_range(0, 5) == 0) clear_fb();
      ra = 12'($urandom_range(12'h300, 12'hEF0));
      rn = $urandom_range(0, 15);
      for (int i = 0; i < rn; i++) poke(ra + 12'(i), 8'($urandom));
      do_draw($sformatf("rnd%0d", t), ra, rn, $urandom_range(0, 255),
              $urandom_range(0, 255), 1'($urandom_range(0, 1)));
    end

    @(negedge clk);
    check("protocol", 32'(proto_err), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
